uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Parametrised UART transmit engine: frame controller, serializer, parity generator and baud-rate divider in one block. It accepts a parallel word on a valid strobe and drives a complete serial frame on `tx_out`. The frame has a start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, and 1 or 2 stop bits. Per-frame configuration is latched at acceptance. The block sits between the system-side producer and the UART pad.

## Interface
- DATA_WIDTH, 8: data bits per frame (5..9 supported).
- PRESCALE_WIDTH, 16: width of the `prescale` input.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  word to transmit; sampled only on acceptance.
- data_valid  input  1  request; accepted only in IDLE.
- par_en  input  1  1 = insert parity bit.
- par_typ  input  1  0 = even, 1 = odd parity.
- two_stop  input  1  1 = two stop bits.
- prescale  input  PRESCALE_WIDTH  clk cycles per bit; 0 is treated as 1.
- tx_out  output  1  serial line; idle high.
- busy  output  1  high from acceptance until the frame completes.
- done  output  1  single-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: `tx_out`=1, `busy`=0.
  - `data_valid`=1 is an acceptance.
  - On acceptance, latch `data_in` into the shift register.
  - Latch `par_en`, `par_typ`, `two_stop` and the effective prescale P = max(prescale,1).
  - Compute parity from the latched word: even = XOR of bits, odd = inverted XOR.
  - Go to START.
- START: `tx_out`=0 for P cycles, then DATA.
- DATA:
  - `tx_out` = shift-register bit 0 for P cycles per bit.
  - Shift right after each bit.
  - Bit counter 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1: go to PARITY if latched `par_en`, else STOP1.
- PARITY: `tx_out` = latched parity bit for P cycles, then STOP1.
- STOP1: `tx_out`=1 for P cycles, then STOP2 if latched `two_stop`, else IDLE.
- STOP2: `tx_out`=1 for P cycles, then IDLE.
- Baud counter:
  - Counts 0..P-1 within each bit.
  - Clears on every state change and on acceptance.
  - Width PRESCALE_WIDTH, no wrap beyond P-1.
- `data_valid` while `busy`=1 is ignored. No queuing; the producer must re-present the word.
- Changes to `data_in`, config inputs or `prescale` mid-frame have no effect on the current frame.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset (asynchronous, immediate, including mid-frame): state IDLE, `tx_out`=1, `busy`=0, `done`=0, counters 0.
- Acceptance at edge k: after edge k, `tx_out`=0 and `busy`=1. Latency from `data_valid` sample to start bit: 0 cycles after the sampling edge.
- Frame length: L = P × (1 + DATA_WIDTH + par_en + 1 + two_stop) cycles.
- Frame end:
  - At edge k+L, state returns to IDLE.
  - `busy` goes to 0 and `done` goes to 1 for exactly one cycle.
  - `tx_out` remains 1.
- Back-to-back: `data_valid`=1 in the `done` cycle is accepted at edge k+L+1. The minimum inter-frame high gap is therefore 1 cycle beyond the stop bits.
- `data_valid` held high continuously: frames repeat every L+1 cycles, each carrying the `data_in` present at its acceptance edge.
- Deassertion of reset: the first acceptance is possible on the first rising edge after release.

## Test plan
- DATA_WIDTH=8, prescale=4, par_en=0, two_stop=0, data_in=0xA5, one-cycle `data_valid`:
  - `tx_out` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `busy` high 40 cycles.
  - `done` pulses once at cycle 40.
- Same word with par_en=1:
  - par_typ=0 → parity bit 0.
  - par_typ=1 → parity bit 1.
  - two_stop=1 → frame length 48 cycles, final two bits high.
- prescale=0, data_in=0xFF, par_en=0 → each bit 1 cycle, frame length 10, `busy` 10 cycles.
- Continuous `data_valid` with data 0x01 then 0x80, prescale=2, 8N1:
  - Second start bit begins exactly 1 cycle after first frame's `done`.
  - Both words serialized correctly.
- During a frame:
  - Pulse `data_valid` with 0x3C and change `par_en`/`prescale`.
  - Required: current frame unaltered, 0x3C never transmitted, no extra `done`.
- Assert `rst` mid-DATA, asynchronously between edges:
  - `tx_out`=1, `busy`=0, `done`=0 immediately.
  - After release, a new 0x5A frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
// Producer-side bus of the UART transmit engine: word, per-frame config and
// the registered serial line plus status flags.
interface uart_tx_engine_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      data_valid;
    logic                      par_en;
    logic                      par_typ;
    logic                      two_stop;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      tx_out;
    logic                      busy;
    logic                      done;

    modport master (
        output data_in, data_valid, par_en, par_typ, two_stop, prescale,
        input  tx_out, busy, done
    );

    modport slave (
        input  data_in, data_valid, par_en, par_typ, two_stop, prescale,
        output tx_out, busy, done
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, LSB-first serializer, parity generator and
// per-bit baud divider; configuration is captured when a word is accepted.
module uart_tx_engine #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_engine_if.slave    bus
);
    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned PW    = PRESCALE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [PW-1:0]         r_baud;
    logic [PW-1:0]         r_presc_m1;
    logic                  r_par_en;
    logic                  r_two_stop;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic [PW-1:0]         w_presc_m1;
    logic                  w_parity;
    logic                  w_bit_end;

    // A prescale of 0 behaves like 1, so the terminal count saturates at 0.
    assign w_presc_m1 = (bus.prescale == '0) ? '0 : bus.prescale - PW'(1);
    assign w_parity   = (^bus.data_in) ^ bus.par_typ;
    assign w_bit_end  = (r_baud == r_presc_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud     <= '0;
            r_presc_m1 <= '0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_baud <= '0;
                    if (bus.data_valid) begin
                        r_shift    <= bus.data_in;
                        r_par_en   <= bus.par_en;
                        r_two_stop <= bus.two_stop;
                        r_par_bit  <= w_parity;
                        r_presc_m1 <= w_presc_m1;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                default: begin
                    if (!w_bit_end) begin
                        r_baud <= r_baud + PW'(1);
                    end else begin
                        r_baud <= '0;
                        // Each case drives the line value of the next bit period.
                        case (r_state)
                            S_START: begin
                                r_tx      <= r_shift[0];
                                r_shift   <= r_shift >> 1;
                                r_bit_cnt <= '0;
                                r_state   <= S_DATA;
                            end
                            S_DATA: begin
                                if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                                    if (r_par_en) begin
                                        r_tx    <= r_par_bit;
                                        r_state <= S_PARITY;
                                    end else begin
                                        r_tx    <= 1'b1;
                                        r_state <= S_STOP1;
                                    end
                                end else begin
                                    r_tx      <= r_shift[0];
                                    r_shift   <= r_shift >> 1;
                                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                                end
                            end
                            S_PARITY: begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP1;
                            end
                            S_STOP1: begin
                                r_tx <= 1'b1;
                                if (r_two_stop) begin
                                    r_state <= S_STOP2;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_state <= S_IDLE;
                                end
                            end
                            default: begin
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.tx_out = r_tx;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: per-cycle expected line/busy/done queue checked on
// every falling edge, driven from a vector table plus corner-case sequences.
module tb_uart_tx_engine;
    logic clk;
    logic rst;

    uart_tx_engine_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) bus ();

    uart_tx_engine #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic        ts;
        logic [15:0] ps;
        string       frame;
        int          exp_len;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[6];
    int   checks;
    int   failures;
    int   busy_cnt;
    bit   mon_en;

    // Expand a frame string (transmitted order) into per-cycle expectations.
    task automatic push_frame(input string fr, input int p);
        for (int i = 0; i < fr.len(); i++) begin
            for (int c = 0; c < p; c++) begin
                exp_q.push_back('{tx: (fr[i] == 8'h31), busy: 1'b1, done: 1'b0});
            end
        end
        exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic ts, input logic [15:0] ps, input string fr);
        @(posedge clk); #1;
        bus.data_in    = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.two_stop   = ts;
        bus.prescale   = ps;
        bus.data_valid = 1'b1;
        busy_cnt       = 0;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        push_frame(fr, (ps == 16'd0) ? 1 : int'(ps));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s timeout: %0d expected cycles still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %b required %b", name, act, req);
        end
    endtask

    initial begin
        rst            = 1'b1;
        mon_en         = 1'b0;
        checks         = 0;
        failures       = 0;
        busy_cnt       = 0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        bus.two_stop   = 1'b0;
        bus.prescale   = 16'd4;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, "0101001011",   40};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 16'd4, "01010010101",  44};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 16'd4, "01010010111",  44};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b1, 16'd4, "010100101011", 48};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 16'd0, "0111111111",   10};
        vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 16'd3, "000111100111", 36};

        // Per-cycle monitor; an empty queue means the line must sit idle.
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (exp_q.size() > 0) mon_e = exp_q.pop_front();
                    else                  mon_e = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
                    checks++;
                    if ({bus.tx_out, bus.busy, bus.done} !== mon_e) begin
                        failures++;
                        $display("FAIL line t=%0t tx/busy/done got %b%b%b required %b%b%b",
                                 $time, bus.tx_out, bus.busy, bus.done,
                                 mon_e.tx, mon_e.busy, mon_e.done);
                    end
                    if (bus.busy) busy_cnt++;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_tx",   bus.tx_out, 1'b1);
        check_bit("reset_busy", bus.busy,   1'b0);
        check_bit("reset_done", bus.done,   1'b0);
        @(posedge clk); #2;
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 6; v++) begin
            send(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].ts, vecs[v].ps, vecs[v].frame);
            wait_drain("vector_drain");
            checks++;
            if (busy_cnt != vecs[v].exp_len) begin
                failures++;
                $display("FAIL busy_len vec%0d got %0d required %0d", v, busy_cnt, vecs[v].exp_len);
            end
        end

        // Continuous valid: second frame starts one cycle after the first done.
        @(posedge clk); #1;
        bus.data_in    = 8'h01;
        bus.par_en     = 1'b0;
        bus.two_stop   = 1'b0;
        bus.prescale   = 16'd2;
        bus.data_valid = 1'b1;
        @(posedge clk); #1;
        push_frame("0100000001", 2);
        bus.data_in = 8'h80;
        repeat (21) @(posedge clk);
        #1;
        push_frame("0000000011", 2);
        bus.data_valid = 1'b0;
        wait_drain("b2b_drain");

        // Mid-frame request and config changes must not disturb the frame.
        send(8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, "0101001011");
        repeat (8) @(posedge clk);
        #1;
        bus.data_in    = 8'h3C;
        bus.par_en     = 1'b1;
        bus.prescale   = 16'd1;
        bus.data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        wait_drain("midframe_drain");
        checks++;
        if (busy_cnt != 40) begin
            failures++;
            $display("FAIL midframe_busy_len got %0d required 40", busy_cnt);
        end

        // Asynchronous reset in the middle of the data bits.
        send(8'hC3, 1'b0, 1'b0, 1'b0, 16'd4, "0110000111");
        repeat (10) @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst    = 1'b1;
        exp_q.delete();
        #1;
        check_bit("async_rst_tx",   bus.tx_out, 1'b1);
        check_bit("async_rst_busy", bus.busy,   1'b0);
        check_bit("async_rst_done", bus.done,   1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst            = 1'b0;
        bus.data_in    = 8'h5A;
        bus.par_en     = 1'b0;
        bus.two_stop   = 1'b0;
        bus.prescale   = 16'd4;
        bus.data_valid = 1'b1;
        busy_cnt       = 0;
        mon_en         = 1'b1;
        @(posedge clk); #1;
        bus.data_valid = 1'b0;
        push_frame("0010110101", 4);
        wait_drain("post_reset_drain");
        checks++;
        if (busy_cnt != 40) begin
            failures++;
            $display("FAIL post_reset_busy_len got %0d required 40", busy_cnt);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
